// File: rtl/cache_arb_rr_pkg.sv
// Shared cache package: default geometry, cache line types and arbiter state encoding.
package cache_arb_rr_pkg;

    localparam int unsigned CACHE_ADDR_WIDTH = 64;
    localparam int unsigned CACHE_DATA_WIDTH = 128;
    localparam int unsigned CACHE_TAG_WIDTH  = 44;
    localparam int unsigned CACHE_SET_ASSOC  = 8;

    typedef struct packed {
        logic [CACHE_TAG_WIDTH-1:0]  tag;
        logic                        valid;
        logic                        dirty;
        logic [CACHE_DATA_WIDTH-1:0] data;
    } cache_line_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 3,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        pos   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = IDX_W'((32'(ptr) + i) % N);
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                idx      = pos;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_arb_rr.sv
// Round-robin cache port arbiter with lockable grants and a one-cycle tag-compare read response.
module cache_arb_rr
    import cache_arb_rr_pkg::*;
#(
    parameter int unsigned NR_PORTS   = 3,
    parameter int unsigned ADDR_WIDTH = CACHE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = CACHE_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = CACHE_TAG_WIDTH,
    parameter int unsigned SET_ASSOC  = CACHE_SET_ASSOC
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NR_PORTS-1:0]                    req_i,
    input  logic [NR_PORTS-1:0]                    lock_i,
    input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]     way_en_i,
    input  logic [NR_PORTS-1:0]                    we_i,
    input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]    addr_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
    input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]     tag_i,
    output logic [NR_PORTS-1:0]                    gnt_o,
    output logic [NR_PORTS-1:0]                    rvalid_o,
    output logic [SET_ASSOC-1:0]                   hit_way_o,
    output logic                                   hit_o,
    output logic                                   multi_hit_o,
    output logic [SET_ASSOC-1:0]                   sram_req_o,
    output logic [ADDR_WIDTH-1:0]                  sram_addr_o,
    output logic [DATA_WIDTH-1:0]                  sram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                sram_be_o,
    output logic                                   sram_we_o,
    input  logic [SET_ASSOC-1:0][TAG_WIDTH-1:0]    sram_tag_i,
    input  logic [SET_ASSOC-1:0]                   sram_valid_i
);

    localparam int unsigned IDX_W = $clog2(NR_PORTS);

    arb_state_e           state_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     rr_q;
    logic                 inf_valid_q;
    logic [IDX_W-1:0]     inf_id_q;
    logic [SET_ASSOC-1:0] inf_mask_q;

    logic [NR_PORTS-1:0]  elig_c;
    logic [NR_PORTS-1:0]  pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 grant_c;
    logic                 read_start_c;
    int unsigned          hit_cnt;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (32'(i) == NR_PORTS - 1) ? '0 : i + IDX_W'(1);
    endfunction

    // While locked only the owner may compete.
    always_comb begin
        elig_c = req_i;
        if (state_q == ARB_LOCKED) begin
            elig_c = req_i & (NR_PORTS'(1) << owner_q);
        end
    end

    rr_pick #(
        .N (NR_PORTS)
    ) u_rr_pick (
        .req (elig_c),
        .ptr (rr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign grant_c      = !rst_i && (|pick_gnt);
    assign read_start_c = grant_c && !we_i[pick_idx] && (|way_en_i[pick_idx]);

    // Grant and SRAM command follow the winner in the same cycle.
    always_comb begin
        gnt_o        = '0;
        sram_req_o   = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        sram_we_o    = 1'b0;
        if (grant_c) begin
            gnt_o        = pick_gnt;
            sram_req_o   = way_en_i[pick_idx];
            sram_addr_o  = addr_i[pick_idx];
            sram_wdata_o = wdata_i[pick_idx];
            sram_be_o    = be_i[pick_idx];
            sram_we_o    = we_i[pick_idx];
        end
    end

    // Response: compare stored tags against the requester's tag one cycle after grant.
    always_comb begin
        rvalid_o  = '0;
        hit_way_o = '0;
        if (!rst_i && inf_valid_q) begin
            rvalid_o[inf_id_q] = 1'b1;
            for (int unsigned j = 0; j < SET_ASSOC; j++) begin
                hit_way_o[j] = inf_mask_q[j] & sram_valid_i[j] & (sram_tag_i[j] == tag_i[inf_id_q]);
            end
        end
    end

    always_comb begin
        hit_cnt = 0;
        for (int unsigned j = 0; j < SET_ASSOC; j++) begin
            hit_cnt = hit_cnt + 32'(hit_way_o[j]);
        end
        hit_o       = |hit_way_o;
        multi_hit_o = hit_cnt > 1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_q        <= '0;
            inf_valid_q <= 1'b0;
            inf_id_q    <= '0;
            inf_mask_q  <= '0;
        end else begin
            inf_valid_q <= read_start_c;
            if (read_start_c) begin
                inf_id_q   <= pick_idx;
                inf_mask_q <= way_en_i[pick_idx];
            end
            if (state_q == ARB_IDLE) begin
                if (grant_c) begin
                    if (lock_i[pick_idx]) begin
                        state_q <= ARB_LOCKED;
                        owner_q <= pick_idx;
                    end else begin
                        rr_q <= wrap_inc(pick_idx);
                    end
                end
            end else begin
                // Lock releases when the owner drops either its request or its lock.
                if (!req_i[owner_q] || !lock_i[owner_q]) begin
                    state_q <= ARB_IDLE;
                    rr_q    <= wrap_inc(owner_q);
                end
            end
        end
    end

endmodule

// File: doc/cache_arb_rr.md
CACHE_ARB_RR -- requirements
Module: cache_arb_rr

Interface
REQ-001 Param NR_PORTS, default 3, number of requesting ports (2..8).
REQ-002 Param ADDR_WIDTH, default 64, request address width.
REQ-003 Param DATA_WIDTH, default 128, cache line data/write width; BE width = DATA_WIDTH/8.
REQ-004 Param TAG_WIDTH, default 44, tag width.
REQ-005 Param SET_ASSOC, default 8, number of ways.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  clock, all state on rising edge.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 req_i  in  NR_PORTS  per-port access request.
REQ-010 lock_i  in  NR_PORTS  per-port arbitration lock, honoured only while that port is granted.
REQ-011 way_en_i  in  NR_PORTS x SET_ASSOC  per-port way enable.
REQ-012 we_i  in  NR_PORTS  write (1) / read (0).
REQ-013 addr_i, wdata_i, be_i  in  NR_PORTS x ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  per-port payload.
REQ-014 tag_i  in  NR_PORTS x TAG_WIDTH  per-port compare tag, one cycle after grant.
REQ-015 gnt_o  out  NR_PORTS  one-hot grant, same cycle as request.
REQ-016 rvalid_o  out  NR_PORTS  one-hot read response strobe.
REQ-017 hit_way_o  out  SET_ASSOC  per-way hit, valid while any rvalid_o set.
REQ-018 hit_o / multi_hit_o  out  1 / 1  any-way hit / more than one way hit.
REQ-019 sram_req_o  out  SET_ASSOC; sram_addr_o, sram_wdata_o, sram_be_o, sram_we_o  out  matching widths  SRAM command.
REQ-020 sram_tag_i, sram_valid_i  in  SET_ASSOC x TAG_WIDTH / SET_ASSOC  stored tag and valid bit per way, one cycle after sram_req_o.

Function
REQ-021 Winner = first port with req_i set searching from rr_q upward with wrap mod NR_PORTS; gnt_o SHALL be one-hot on the winner, zero if no request.
REQ-022 sram_req_o = way_en_i[winner]; sram_addr/wdata/be/we SHALL mirror winner payload; all zero when no grant.
REQ-023 On grant to port k with lock_i[k]=0, rr_q SHALL update to (k+1) mod NR_PORTS next cycle; with no grant rr_q holds.
REQ-024 States IDLE/LOCKED: grant to k with lock_i[k]=1 -> LOCKED(owner=k); in LOCKED only port k is eligible, other requests see gnt_o=0.
REQ-025 LOCKED -> IDLE on the first cycle lock_i[k]=0 or req_i[k]=0; rr_q then updates to (k+1) mod NR_PORTS.
REQ-026 Granted read with nonzero way_en SHALL set a one-cycle in-flight register (valid, port id, way mask); writes and zero way masks create no response.
REQ-027 Next cycle rvalid_o[id]=1; hit_way_o[j] = mask[j] & sram_valid_i[j] & (sram_tag_i[j]==tag_i[id]).
REQ-028 hit_o = OR of hit_way_o; multi_hit_o = popcount(hit_way_o)>1; all three SHALL be zero when no rvalid_o.
REQ-029 Fully pipelined: one grant per cycle, a new grant may coincide with the previous read's response.
REQ-030 A request deasserted before grant SHALL be dropped silently; no request buffering.

Reset
REQ-031 Reset SHALL set rr_q=0, state IDLE, in-flight valid=0.
REQ-032 Reset SHALL drive gnt_o, rvalid_o, hit_way_o, hit_o, multi_hit_o and all sram_* outputs to 0 in the reset cycle.
REQ-033 Reset asserted while a read is in flight SHALL drop that response; no rvalid_o after reset deasserts.

Structure
REQ-034 Defaults for ADDR/DATA/TAG widths and SET_ASSOC SHALL live in the shared cache package next to the existing cache line types.
REQ-035 Round-robin pick SHALL be one sub-module rr_pick (req, ptr -> one-hot grant, index) for reuse.

Verification
REQ-036 Reset, then req_i=3'b111 reads for 3 cycles -> gnt_o 001, 010, 100; rr_q back to 0.
REQ-037 Port1 read, way_en=8'hFF, sram_tag[5]=tag_i[1]=44'h123, valid[5]=1 -> next cycle rvalid_o=010, hit_way_o=8'h20, hit_o=1.
REQ-038 Ways 2 and 6 both match and valid -> hit_way_o=8'h44, multi_hit_o=1.
REQ-039 Port2 lock_i=1 for 4 cycles while port0 requests -> gnt_o=100 for 4 cycles, then port0 granted.
REQ-040 Port0 write, then rst_i during a port1 read -> no rvalid_o for either; first post-reset grant goes to the lowest requesting port.
